usb_in_arbiter: RTL and testbench

USB_IN_ARBITER -- requirements
Module: usb_in_arbiter

---
 rtl/usb_arb_pkg.sv | 21 ++
 rtl/usb_in_arbiter_rr_pick.sv | 30 +++
 rtl/usb_in_arbiter.sv | 149 ++++++++++++++
 tb/tb_usb_in_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and defaults for the usb_cdc IN-channel arbiter.
package usb_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_MAX_BURST    = 64;
   localparam int DEF_IDLE_TIMEOUT = 16;

   typedef struct packed {
      logic       valid;
      logic [7:0] data;
   } out_beat_t;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/usb_in_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping.
module rr_pick
   import usb_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] pick_o
);

   logic found;
   int   idx;

   always_comb begin
      pick_o = '0;
      found  = 1'b0;
      idx    = 0;
      // i == NUM_REQ wraps back to last_i itself, so a lone requester can be re-granted
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last_i) + i) % NUM_REQ;
         if (!found && req_i[idx]) begin
            pick_o[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter merging NUM_REQ byte streams onto one usb_cdc IN channel.
// Define USB_ARB_TIMEOUT_EN to release a grant whose requester stalls IDLE_TIMEOUT cycles.
module usb_in_arbiter
   import usb_arb_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int MAX_BURST    = DEF_MAX_BURST,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ-1:0]   req_last_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [7:0]           usb_data_o,
   output logic                 usb_valid_o,
   input  logic                 usb_ready_i,
   output logic [NUM_REQ-1:0]   grant_o
);

   localparam int PTR_W = ptr_w(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   burst_q, burst_d;
   out_beat_t          out_q, out_d;

   logic [NUM_REQ-1:0] pick;
   logic               out_free, accept, acc_last, release_now, timeout;
   logic [7:0]         acc_byte;
   logic [PTR_W-1:0]   grant_idx;

   rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
      .req_i  (req_valid_i),
      .last_i (last_q),
      .pick_o (pick)
   );

   // the output register can take a byte when empty or draining this cycle
   assign out_free    = ~out_q.valid | usb_ready_i;
   assign req_ready_o = (state_q == GRANT) ? (grant_q & {NUM_REQ{out_free}}) : '0;
   assign accept      = |(req_ready_o & req_valid_i);

   always_comb begin
      acc_byte  = '0;
      acc_last  = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            acc_byte  = req_data_i[8*k +: 8];
            acc_last  = req_last_i[k];
            grant_idx = PTR_W'(k);
         end
      end
   end

`ifdef USB_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
   logic [TO_W-1:0] idle_q, idle_d;
   logic            gnt_valid;

   assign gnt_valid = |(grant_q & req_valid_i);

   always_comb begin
      idle_d  = idle_q;
      timeout = 1'b0;
      if (state_q != GRANT || gnt_valid) begin
         idle_d = '0;
      end else if (idle_q == TO_W'(IDLE_TIMEOUT - 1)) begin
         timeout = 1'b1;
         idle_d  = '0;
      end else begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_q <= '0;
      else     idle_q <= idle_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // last and the MAX_BURST count on the same byte fold into one release
   assign release_now = accept && (acc_last || burst_q == CNT_W'(MAX_BURST - 1));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      burst_d = burst_q;
      out_d   = out_q;

      if (accept) begin
         out_d.valid = 1'b1;
         out_d.data  = acc_byte;
      end else if (usb_ready_i) begin
         out_d.valid = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (|req_valid_i) begin
               state_d = GRANT;
               grant_d = pick;
               burst_d = '0;
            end
         end
         GRANT: begin
            if (accept) burst_d = burst_q + 1'b1;
            if (release_now || timeout) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = grant_idx;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= PTR_INIT;
         burst_q <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         out_q   <= out_d;
      end
   end

   assign usb_valid_o = out_q.valid;
   assign usb_data_o  = out_q.data;
   assign grant_o     = grant_q;

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Self-checking bench for usb_in_arbiter: queue-fed requesters, byte scoreboard, directed corners.
module tb_usb_in_arbiter;

   localparam int NR = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [8*NR-1:0] req_data_i;
   logic [NR-1:0]   req_valid_i, req_last_i, req_ready_o, grant_o;
   logic [7:0]      usb_data_o;
   logic            usb_valid_o, usb_ready_i;

   usb_in_arbiter #(.NUM_REQ(NR), .MAX_BURST(64), .IDLE_TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_data_i  (req_data_i),
      .req_valid_i (req_valid_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .usb_data_o  (usb_data_o),
      .usb_valid_o (usb_valid_o),
      .usb_ready_i (usb_ready_i),
      .grant_o     (grant_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         src;
      logic [7:0] data;
      bit         last;
      int         pos;
   } vec_t;

   int         n_tests = 0, n_fail = 0;
   logic [7:0] src_d [NR][$];
   bit         src_l [NR][$];
   logic [7:0] sb[$], out_log[$], first_log[$];
   int         gnt_log[$], burst_log[$];
   logic [NR-1:0] prev_g = '0;
   int         cur_cnt = 0, n_acc = 0, n_pop = 0;
   bit         first_pend = 1'b0, acc_pend = 1'b0;
   logic [7:0] acc_byte = '0, exp_b;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int oh2i(input logic [NR-1:0] v);
      int r = -1;
      for (int k = 0; k < NR; k++) if (v[k]) r = k;
      return r;
   endfunction

   task automatic push(input int k, input logic [7:0] d, input bit l);
      src_d[k].push_back(d);
      src_l[k].push_back(l);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // requester model: present queue head, one byte per handshake
   initial begin
      req_valid_i = '0;
      req_last_i  = '0;
      req_data_i  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NR; k++) begin
            if (src_d[k].size() > 0) begin
               req_valid_i[k]       = 1'b1;
               req_data_i[8*k +: 8] = src_d[k][0];
               req_last_i[k]        = src_l[k][0];
            end else begin
               req_valid_i[k]       = 1'b0;
               req_data_i[8*k +: 8] = 8'h00;
               req_last_i[k]        = 1'b0;
            end
         end
      end
   end

   // monitor: scoreboard, one-cycle latency, grant order and burst lengths
   always @(negedge clk) begin
      if (!rst) begin
         if (acc_pend) begin
            chk("out_latency_valid", usb_valid_o, 1);
            chk("out_latency_data", usb_data_o, acc_byte);
         end
         acc_pend = 1'b0;
         if (usb_valid_o && usb_ready_i) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow: got byte %0h expected none", usb_data_o);
            end else begin
               exp_b = sb.pop_front();
               chk("sb_data", usb_data_o, exp_b);
               out_log.push_back(usb_data_o);
               n_pop++;
            end
         end
         if (grant_o !== prev_g) begin
            if (prev_g != '0) burst_log.push_back(cur_cnt);
            if (grant_o != '0) begin
               gnt_log.push_back(oh2i(grant_o));
               cur_cnt    = 0;
               first_pend = 1'b1;
            end
         end
         prev_g = grant_o;
         for (int k = 0; k < NR; k++) begin
            if (req_valid_i[k] && req_ready_o[k]) begin
               chk("no_interleave", grant_o[k], 1);
               if (src_d[k].size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL src_underflow: got accept on %0d expected none", k);
               end else begin
                  acc_byte = src_d[k].pop_front();
                  void'(src_l[k].pop_front());
                  sb.push_back(acc_byte);
                  acc_pend = 1'b1;
                  n_acc++;
                  cur_cnt++;
                  if (first_pend) begin
                     first_log.push_back(acc_byte);
                     first_pend = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      for (int k = 0; k < NR; k++) begin
         src_d[k].delete();
         src_l[k].delete();
      end
      sb.delete(); out_log.delete(); first_log.delete();
      gnt_log.delete(); burst_log.delete();
      prev_g = '0; cur_cnt = 0; n_acc = 0; n_pop = 0;
      first_pend = 1'b0; acc_pend = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int  i = 0;
      bit  done = 1'b0;
      while (!done && i < budget) begin
         done = (src_d[0].size() == 0) && (src_d[1].size() == 0) && (sb.size() == 0) && !usb_valid_o;
         if (!done) begin
            step();
            i++;
         end
      end
      chk(name, done, 1);
   endtask

   vec_t tbl[8];
   int   exp_g[4];

   initial begin
      int i;
      tbl = '{'{0, 8'h10, 1'b0, 0}, '{0, 8'h11, 1'b1, 1}, '{0, 8'h12, 1'b0, 4}, '{0, 8'h13, 1'b1, 5},
              '{1, 8'h20, 1'b0, 2}, '{1, 8'h21, 1'b1, 3}, '{1, 8'h22, 1'b0, 6}, '{1, 8'h23, 1'b1, 7}};
      exp_g = '{0, 1, 0, 1};
      usb_ready_i = 1'b1;

      // reset values
      @(negedge clk);
      chk("rst_grant", grant_o, 0);
      chk("rst_ready", req_ready_o, 0);
      chk("rst_valid", usb_valid_o, 0);
      chk("rst_data", usb_data_o, 8'h00);
      step();
      rst = 1'b0;

      // three-byte message from requester 0
      push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
      step();
      @(negedge clk);
      chk("t1_req_cycle_ready", req_ready_o, 0);
      chk("t1_req_cycle_grant", grant_o, 0);
      @(negedge clk);
      chk("t1_grant0", grant_o, 2'b01);
      chk("t1_ready0", req_ready_o, 2'b01);
      step();
      wait_drain("t1_drain", 20);
      chk("t1_count", out_log.size(), 3);
      chk("t1_b0", out_log.size() > 0 ? 32'(out_log[0]) : 32'hFFFF, 8'hA1);
      chk("t1_b1", out_log.size() > 1 ? 32'(out_log[1]) : 32'hFFFF, 8'hA2);
      chk("t1_b2", out_log.size() > 2 ? 32'(out_log[2]) : 32'hFFFF, 8'hA3);
      chk("t1_grant_idle", grant_o, 0);

      // table: both requesters, two 2-byte messages each
      do_reset();
      for (int v = 0; v < 8; v++) push(tbl[v].src, tbl[v].data, tbl[v].last);
      wait_drain("t2_drain", 60);
      chk("t2_count", out_log.size(), 8);
      for (int v = 0; v < 8; v++)
         chk("t2_order", out_log.size() > tbl[v].pos ? 32'(out_log[tbl[v].pos]) : 32'hFFFF, 32'(tbl[v].data));
      chk("t2_grants", gnt_log.size(), 4);
      for (int g = 0; g < 4; g++) begin
         chk("t2_grant_seq", gnt_log.size() > g ? gnt_log[g] : -1, exp_g[g]);
         chk("t2_burst_len", burst_log.size() > g ? burst_log[g] : -1, 2);
      end

      // 100-byte stream without last: MAX_BURST release, pending peer served, resume at byte 65
      do_reset();
      for (int b = 0; b < 100; b++) push(1, 8'(b), 0);
      i = 0;
      while (grant_o !== 2'b10 && i < 10) begin step(); i++; end
      chk("t3_grant1", grant_o, 2'b10);
      push(0, 8'hE0, 0); push(0, 8'hE1, 1);
      i = 0;
      while (gnt_log.size() < 3 && i < 300) begin step(); i++; end
      chk("t3_grants", gnt_log.size() >= 3, 1);
      chk("t3_g0", gnt_log.size() > 0 ? gnt_log[0] : -1, 1);
      chk("t3_g1", gnt_log.size() > 1 ? gnt_log[1] : -1, 0);
      chk("t3_g2", gnt_log.size() > 2 ? gnt_log[2] : -1, 1);
      chk("t3_burst_max", burst_log.size() > 0 ? burst_log[0] : -1, 64);
      chk("t3_burst_peer", burst_log.size() > 1 ? burst_log[1] : -1, 2);
      chk("t3_resume_byte", first_log.size() > 2 ? 32'(first_log[2]) : 32'hFFFF, 8'd64);

      // usb_ready_i low for 5 cycles mid-burst
      do_reset();
      for (int b = 0; b < 10; b++) push(0, 8'h30 + 8'(b), b == 9);
      i = 0;
      while (n_acc < 3 && i < 20) begin step(); i++; end
      chk("t4_started", n_acc >= 3, 1);
      usb_ready_i = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("t4_ready_low", req_ready_o, 0);
         chk("t4_valid_hold", usb_valid_o, 1);
         chk("t4_data_hold", sb.size() == 1 ? 32'(sb[0]) : 32'hFFFF, 32'(usb_data_o));
      end
      step();
      usb_ready_i = 1'b1;
      wait_drain("t4_drain", 30);
      chk("t4_pops", n_pop, 10);
      for (int b = 0; b < 10; b++)
         chk("t4_seq", out_log.size() > b ? 32'(out_log[b]) : 32'hFFFF, 32'h30 + b);

      // requester goes quiet while granted
      do_reset();
      push(0, 8'h70, 0); push(0, 8'h71, 0);
      wait_drain("t5_drain", 20);
      chk("t5_held_short", grant_o, 2'b01);
      repeat (25) step();
`ifdef USB_ARB_TIMEOUT_EN
      chk("t5_timeout_release", grant_o, 0);
`else
      chk("t5_grant_held", grant_o, 2'b01);
`endif

      // reset mid-burst with a byte in flight
      do_reset();
      for (int b = 0; b < 20; b++) push(0, 8'h50 + 8'(b), b == 19);
      i = 0;
      while (!(n_acc >= 4 && usb_valid_o) && i < 20) begin step(); i++; end
      chk("t6_inflight", usb_valid_o, 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", usb_valid_o, 0);
      chk("t6_rst_data", usb_data_o, 8'h00);
      chk("t6_rst_grant", grant_o, 0);
      chk("t6_rst_ready", req_ready_o, 0);
      do_reset();
      push(0, 8'h60, 1); push(1, 8'h61, 1);
      wait_drain("t6_drain", 20);
      chk("t6_first_grant", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
      chk("t6_second_grant", gnt_log.size() > 1 ? gnt_log[1] : -1, 1);
      chk("t6_first_byte", out_log.size() > 0 ? 32'(out_log[0]) : 32'hFFFF, 8'h60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
